mem_lsu: RTL
============

# mem_lsu

Load/store unit that acts as the initiator for the single-port data memory (`DataMem`). It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It issues word-aligned read/write cycles on the data-memory port, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data on a one-cycle response pulse.

## Interface
Parameters:
- none; data and address widths are fixed at 32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- io_req_valid  in  1  request present
- io_req_ready  out  1  unit can accept; high only in IDLE
- io_req_wr  in  1  1 = store, 0 = load
- io_req_typ  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- io_req_addr  in  32  byte address
- io_req_wdata  in  32  store data, right-justified
- io_resp_valid  out  1  one-cycle completion pulse; no backpressure
- io_resp_data  out  32  extended load data; 0 for stores
- io_resp_misaligned  out  1  misalignment flag, qualified by io_resp_valid
- io_mem_en  out  1  memory cycle enable
- io_mem_func  out  2  0 = read, 1 = write; other codes never driven
- io_mem_addr  out  32  word-aligned byte address, bits [1:0] = 0
- io_mem_wr_data  out  32  full write word
- io_mem_rd_data  in  32  read word, valid the cycle after a read is issued

## Operation
- **States:** IDLE, RD, WR, MERGE, RESP.
- **IDLE:** a request is accepted when io_req_valid and io_req_ready are both high. The request fields are registered.
  - Load → RD
  - SW → WR
  - SB/SH → RD, with the RMW flag set
- **RD:**
  - Drives io_mem_en=1, io_mem_func=0, io_mem_addr={addr[31:2],2'b00}.
  - Next state: MERGE if RMW, else RESP. RESP captures io_mem_rd_data into the data register.
- **MERGE:**
  - Merges the store byte or halfword into io_mem_rd_data at lane addr[1:0]. Byte order is little-endian: lane 0 = bits [7:0].
  - Writes the merged word with io_mem_en=1, io_mem_func=1, then goes to RESP.
- **WR:** writes io_req_wdata unchanged with io_mem_en=1, io_mem_func=1, then goes to RESP.
- **RESP:** io_resp_valid=1 for exactly one cycle, then IDLE.
- **Load extraction:** selects the lane by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended; W passes through.
- **Reserved typ codes:** 011, 110, 111 are treated as W. BU/HU on a store are treated as B/H.
- io_mem_en is low in IDLE and RESP; the memory is never accessed outside RD, WR and MERGE.

## Timing
- **Reset values:** state=IDLE, io_req_ready=1, io_resp_valid=0, io_resp_data=0, io_resp_misaligned=0, io_mem_en=0, io_mem_func=0, io_mem_addr=0, io_mem_wr_data=0.
- **Latency**, counted from the accept edge (cycle 0):
  - Load: response in cycle 2.
  - SW: response in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, response in cycle 3.
- io_resp_data holds its value until the next response. Stores return 0.
- **Throughput:** the next accept is the cycle after RESP. A request that is held valid during a busy period is accepted when IDLE returns.
- **Reset mid-operation:** a write driven in the same cycle as reset still commits, because reset is synchronous. On the next cycle the unit is in IDLE with io_mem_en=0, and no response is generated for the aborted request.

## Configuration
- **`MEM_LSU_MISALIGN_TRAP_EN` defined:**
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned request skips memory entirely: IDLE → RESP, so the response comes in cycle 1 with io_resp_misaligned=1 and io_resp_data=0.
  - io_mem_en stays 0 throughout.
- **`MEM_LSU_MISALIGN_TRAP_EN` undefined:**
  - The low address bits are forced to natural alignment: addr[0] is cleared for H, addr[1:0] for W.
  - The access then proceeds normally, and io_resp_misaligned is tied to 0.

## Test plan
- Preload word 0x100 = 0x80FF_7F01.
  - LB @0x101 → resp_data 0x0000_007F in cycle 2.
  - LB @0x103 → 0xFFFF_FF80.
  - LBU @0x103 → 0x0000_0080.
  - LH @0x102 → 0xFFFF_80FF.
- SW 0xDEADBEEF @0x200 → one write cycle with io_mem_addr 0x200, response in cycle 2. A following LW @0x200 returns 0xDEADBEEF.
- Word 0x300 = 0x1122_3344. SB 0xAB @0x302 → read in cycle 1, write of 0x11AB_3344 in cycle 2, response in cycle 3. SH 0xCAFE @0x300 → 0x11AB_CAFE.
- LW @0x206:
  - Trap build: response in cycle 1 with misaligned=1, and io_mem_en never asserted.
  - Non-trap build: reads 0x204.
- Back-to-back requests with valid held high: io_req_ready is low from cycle 1 through RESP, and the second request is accepted the cycle after the first response.
- Assert reset during MERGE of an SB: the write commits that cycle, there is no response, and all outputs hold reset values the following cycle.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for the single-port data memory with RMW sub-word stores.
// Optional misalignment trap enabled by defining MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_wr,
  input  logic [2:0]  io_req_typ,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_data,
  output logic        io_resp_misaligned,
  output logic        io_mem_en,
  output logic [1:0]  io_mem_func,
  output logic [31:0] io_mem_addr,
  output logic [31:0] io_mem_wr_data,
  input  logic [31:0] io_mem_rd_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_WR    = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [2:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic        rmw_q, rmw_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;

  logic [1:0]  req_size;
  logic        req_mis;
  logic [31:0] req_addr;
  logic [4:0]  shamt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] resp_val;
  logic [31:0] mask;
  logic [31:0] merged;

  // Reserved funct3 codes fall through to word size
  assign req_size = (io_req_typ[1:0] == 2'b00) ? SZ_B :
                    (io_req_typ[1:0] == 2'b01) ? SZ_H : SZ_W;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign req_mis = ((req_size == SZ_H) && io_req_addr[0]) ||
                   ((req_size == SZ_W) && (io_req_addr[1:0] != 2'b00));
  assign req_addr = io_req_addr;
  assign io_resp_misaligned = (state_q == S_RESP) && mis_q;
`else
  assign req_mis = 1'b0;
  assign req_addr = (req_size == SZ_W) ? {io_req_addr[31:2], 2'b00} :
                    (req_size == SZ_H) ? {io_req_addr[31:1], 1'b0} :
                    io_req_addr;
  assign io_resp_misaligned = 1'b0;
`endif

  assign shamt = {addr_q[1:0], 3'b000};

  always_comb begin
    lane_b = io_mem_rd_data[7:0];
    unique case (addr_q[1:0])
      2'd0: lane_b = io_mem_rd_data[7:0];
      2'd1: lane_b = io_mem_rd_data[15:8];
      2'd2: lane_b = io_mem_rd_data[23:16];
      2'd3: lane_b = io_mem_rd_data[31:24];
    endcase
  end

  assign lane_h = addr_q[1] ? io_mem_rd_data[31:16] : io_mem_rd_data[15:0];

  always_comb begin
    load_val = io_mem_rd_data;
    if (size_q == SZ_B)
      load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
    else if (size_q == SZ_H)
      load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign resp_val = (wr_q || mis_q) ? 32'b0 : load_val;
`else
  assign resp_val = wr_q ? 32'b0 : load_val;
`endif

  assign mask = ((size_q == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
  assign merged = (io_mem_rd_data & ~mask) | ((wdata_q << shamt) & mask);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rmw_d   = rmw_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (io_req_valid) begin
          wr_d    = io_req_wr;
          rmw_d   = io_req_wr && (req_size != SZ_W);
          uns_d   = io_req_typ[2];
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = io_req_wdata;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
          mis_d   = req_mis;
`endif
          if (req_mis)
            state_d = S_RESP;
          else if (io_req_wr && (req_size == SZ_W))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD:    state_d = rmw_q ? S_MERGE : S_RESP;
      S_WR:    state_d = S_RESP;
      S_MERGE: state_d = S_RESP;
      S_RESP: begin
        data_d  = resp_val;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      rmw_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_W;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      data_q  <= 32'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rmw_q   <= rmw_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Response data is live during the pulse and then held by data_q
  assign io_req_ready   = (state_q == S_IDLE);
  assign io_resp_valid  = (state_q == S_RESP);
  assign io_resp_data   = io_resp_valid ? resp_val : data_q;
  assign io_mem_en      = (state_q == S_RD) || (state_q == S_WR) ||
                          (state_q == S_MERGE);
  assign io_mem_func    = ((state_q == S_WR) || (state_q == S_MERGE)) ?
                          2'd1 : 2'd0;
  assign io_mem_addr    = io_mem_en ? {addr_q[31:2], 2'b00} : 32'b0;
  assign io_mem_wr_data = (state_q == S_WR)    ? wdata_q :
                          (state_q == S_MERGE) ? merged  : 32'b0;

endmodule
